// File: rtl/event_trigger_pattern_recorder.sv
// event_trigger_pattern_recorder
//
// Turns trigger levels into registered one-cycle flags and, after each
// accepted event, collects a coincidence pattern over a programmable
// window. Each {event number, pattern} record goes into a small
// first-word-fall-through FIFO that is read out with valid/ready.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_n_i          synchronous active-low reset
//   enable_i         allow new events to be accepted
//   g_trigger_i      combined trigger level
//   triggers_i       individual trigger levels
//   window_i         coincidence window length, sampled at acceptance
//   event_flag_o     one-cycle pulse per accepted event
//   trig_flag_o      one-cycle pulse per rising edge of each trigger bit
//   busy_o           an event is being collected or pushed
//   rec_valid_o      FIFO head record valid
//   rec_ready_i      consumer takes the head record
//   rec_evnum_o      head record event number
//   rec_pattern_o    head record trigger pattern
//   fifo_count_o     records held
//   overflow_count_o saturating count of dropped records
module event_trigger_pattern_recorder #(
    parameter int NUM_TRIGGERS = 4,
    parameter int WINDOW_W     = 4,
    parameter int EVNUM_W      = 16,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    g_trigger_i,
    input  logic [NUM_TRIGGERS-1:0] triggers_i,
    input  logic [WINDOW_W-1:0]     window_i,
    output logic                    event_flag_o,
    output logic [NUM_TRIGGERS-1:0] trig_flag_o,
    output logic                    busy_o,
    output logic                    rec_valid_o,
    input  logic                    rec_ready_i,
    output logic [EVNUM_W-1:0]      rec_evnum_o,
    output logic [NUM_TRIGGERS-1:0] rec_pattern_o,
    output logic [DEPTH_LOG2:0]     fifo_count_o,
    output logic [7:0]              overflow_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WINDOW,
        S_PUSH
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------
    logic                    g_d_q;
    logic [NUM_TRIGGERS-1:0] trig_d_q;
    logic                    g_edge;
    logic [NUM_TRIGGERS-1:0] trig_edge;

    // The delayed copies track the inputs during reset as well, so a
    // level that is already high at release is not seen as an edge.
    always_ff @(posedge clk_i) begin
        g_d_q    <= g_trigger_i;
        trig_d_q <= triggers_i;
    end

    assign g_edge    = g_trigger_i & ~g_d_q;
    assign trig_edge = triggers_i & ~trig_d_q;

    // ------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------
    logic                    accept;
    logic                    rec_push;
    logic [WINDOW_W-1:0]     cnt_q;
    logic [NUM_TRIGGERS-1:0] pattern_q;
    logic [EVNUM_W-1:0]      evnum_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rec_push = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (g_edge && enable_i) begin
                    accept = 1'b1;
                    if (window_i == '0) begin
                        state_d = S_PUSH;
                    end else begin
                        state_d = S_WINDOW;
                    end
                end
            end
            S_WINDOW: begin
                if (cnt_q == WINDOW_W'(1)) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                rec_push = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    // ------------------------------------------------------------
    // FIFO status (needed by the datapath for drop accounting)
    // ------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic                  fifo_rd;

    // Fullness is judged before any same-cycle pop, so a push into a
    // full FIFO is dropped even if the head is leaving on this clock.
    assign fifo_full = (count_q == FULL_COUNT);
    assign fifo_wr   = rec_push & ~fifo_full;
    assign fifo_rd   = rec_valid_o & rec_ready_i;

    // ------------------------------------------------------------
    // Event datapath and flags
    // ------------------------------------------------------------
    logic                    event_flag_q;
    logic [NUM_TRIGGERS-1:0] trig_flag_q;
    logic [7:0]              overflow_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            event_flag_q <= 1'b0;
            trig_flag_q  <= '0;
            pattern_q    <= '0;
            cnt_q        <= '0;
            evnum_q      <= '0;
            overflow_q   <= '0;
        end else begin
            event_flag_q <= accept;
            trig_flag_q  <= trig_edge;

            if (accept) begin
                pattern_q <= trig_edge;
                cnt_q     <= window_i;
            end else if (state_q == S_WINDOW) begin
                pattern_q <= pattern_q | trig_edge;
                cnt_q     <= cnt_q - WINDOW_W'(1);
            end

            // Dropped records still consume an event number so the
            // loss shows up as a gap downstream.
            if (rec_push) begin
                evnum_q <= evnum_q + EVNUM_W'(1);
                if (fifo_full && (overflow_q != 8'hFF)) begin
                    overflow_q <= overflow_q + 8'd1;
                end
            end
        end
    end

    assign event_flag_o     = event_flag_q;
    assign trig_flag_o      = trig_flag_q;
    assign overflow_count_o = overflow_q;

    // ------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------
    logic [EVNUM_W-1:0]      mem_evnum   [DEPTH];
    logic [NUM_TRIGGERS-1:0] mem_pattern [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_n_i && fifo_wr) begin
            mem_evnum[wr_ptr_q]   <= evnum_q;
            mem_pattern[wr_ptr_q] <= pattern_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            unique case ({fifo_wr, fifo_rd})
                2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rec_valid_o  = (count_q != '0);
    assign fifo_count_o = count_q;

    // Storage is not reset; the head is masked so an empty FIFO
    // always presents zeros.
    assign rec_evnum_o   = rec_valid_o ? mem_evnum[rd_ptr_q] : '0;
    assign rec_pattern_o = rec_valid_o ? mem_pattern[rd_ptr_q] : '0;

endmodule

// File: tb/tb_event_trigger_pattern_recorder.sv
// tb_event_trigger_pattern_recorder
// Directed scenarios plus randomized traffic against a timestamp-based model.
module tb_event_trigger_pattern_recorder;

    localparam int NT    = 4;
    localparam int WW    = 4;
    localparam int EW    = 16;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
    localparam int VW    = 1 + NT + 1 + 1 + EW + NT + (DL + 1) + 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          g_trig;
    logic [NT-1:0] trigs;
    logic [WW-1:0] win;
    logic          ready;

    logic          event_flag;
    logic [NT-1:0] trig_flag;
    logic          busy;
    logic          valid;
    logic [EW-1:0] evnum;
    logic [NT-1:0] pattern;
    logic [DL:0]   count;
    logic [7:0]    ovf;

    always #5 clk = ~clk;

    event_trigger_pattern_recorder #(
        .NUM_TRIGGERS(NT),
        .WINDOW_W    (WW),
        .EVNUM_W     (EW),
        .DEPTH_LOG2  (DL)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .enable_i        (enable),
        .g_trigger_i     (g_trig),
        .triggers_i      (trigs),
        .window_i        (win),
        .event_flag_o    (event_flag),
        .trig_flag_o     (trig_flag),
        .busy_o          (busy),
        .rec_valid_o     (valid),
        .rec_ready_i     (ready),
        .rec_evnum_o     (evnum),
        .rec_pattern_o   (pattern),
        .fifo_count_o    (count),
        .overflow_count_o(ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------
    // Reference model: each accepted event is a pending record with
    // a close time (T+W) and a push time (T+W+1); records live in a
    // queue of at most DEPTH entries.
    // ------------------------------------------------------------
    logic [EW+NT-1:0] mq[$];
    logic [EW+NT-1:0] m_head;
    logic [EW+NT-1:0] m_tmp;
    logic             m_event;
    logic [NT-1:0]    m_trig;
    logic             m_busy;
    logic             m_valid;
    logic [EW-1:0]    m_evnum;
    logic [NT-1:0]    m_pat;
    logic [DL:0]      m_count;
    logic [7:0]       m_ovf;
    logic [EW-1:0]    m_next_ev;
    logic [NT-1:0]    m_acc;
    logic             m_gprev;
    logic [NT-1:0]    m_tprev;
    logic             m_ge;
    logic [NT-1:0]    m_te;
    bit               m_full;
    bit               m_pop;
    bit               m_pending = 1'b0;
    int               m_close;
    int               m_push;
    int               cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            mq.delete();
            m_next_ev = '0;
            m_ovf     = '0;
            m_pending = 1'b0;
            m_event   = 1'b0;
            m_trig    = '0;
        end else begin
            m_ge    = g_trig & ~m_gprev;
            m_te    = trigs & ~m_tprev;
            m_full  = (mq.size() == DEPTH);
            m_pop   = (mq.size() > 0) && ready;
            m_event = 1'b0;
            m_trig  = m_te;
            if (m_pop) m_tmp = mq.pop_front();
            if (m_pending) begin
                if (cyc <= m_close) m_acc = m_acc | m_te;
                if (cyc == m_push) begin
                    if (!m_full) mq.push_back({m_next_ev, m_acc});
                    else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
                    m_next_ev = m_next_ev + 1'b1;
                    m_pending = 1'b0;
                end
            end else if (m_ge && enable) begin
                m_pending = 1'b1;
                m_acc     = m_te;
                m_close   = cyc + int'(win);
                m_push    = m_close + 1;
                m_event   = 1'b1;
            end
        end
        m_gprev = g_trig;
        m_tprev = trigs;
        m_busy  = m_pending;
        m_valid = (mq.size() > 0);
        m_count = (DL+1)'(mq.size());
        if (m_valid) m_head = mq[0];
        else m_head = '0;
        m_evnum = m_head[EW+NT-1:NT];
        m_pat   = m_head[NT-1:0];
    end

    logic [VW-1:0] dut_vec;
    logic [VW-1:0] mdl_vec;
    assign dut_vec = {event_flag, trig_flag, busy, valid,
                      evnum, pattern, count, ovf};
    assign mdl_vec = {m_event, m_trig, m_busy, m_valid,
                      m_evnum, m_pat, m_count, m_ovf};

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        g_trig = 1'b0;
        trigs  = '0;
        win    = '0;
        ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        g_trig = 1'b1;
        trigs  = 4'b1111;
        win    = 4'd0;
        ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (event_flag !== 1'b0 || trig_flag !== 4'b0000 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_release k=%0d ev=%b tf=%b cnt=%0d want 0/0000/0",
                         k, event_flag, trig_flag, count);
            end
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL reset_model dut=%h model=%h", dut_vec, mdl_vec);
            end
        end
        g_trig = 1'b0;
        trigs  = '0;
        @(negedge clk);
    endtask

    task automatic test_window_pattern();
        do_reset();
        win    = 4'd3;
        g_trig = 1'b1;
        trigs  = 4'b0001;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL window_model k=%0d dut=%h model=%h", k, dut_vec, mdl_vec);
            end
            if (k == 0) begin
                n_checks++;
                if (event_flag !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL window_accept ev=%b busy=%b want 1/1", event_flag, busy);
                end
                g_trig = 1'b0;
            end
            if (k == 1) begin
                n_checks++;
                if (event_flag !== 1'b0) begin
                    n_fail++;
                    $display("FAIL window_flag_once ev=%b want 0", event_flag);
                end
            end
            if (k == 2) trigs = 4'b0101;
            if (k == 3) begin
                trigs = 4'b1101;
                n_checks++;
                if (valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL window_early_valid valid=%b want 0", valid);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (valid !== 1'b1 || evnum !== 16'd0 || pattern !== 4'b0101 ||
                    trig_flag !== 4'b1000 || count !== 3'd1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL window_record v=%b ev=%0d pat=%b tf=%b cnt=%0d busy=%b want 1/0/0101/1000/1/0",
                             valid, evnum, pattern, trig_flag, count, busy);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        win = 4'd0;
        for (int e = 0; e < 5; e++) begin
            g_trig = 1'b1;
            @(negedge clk);
            g_trig = 1'b0;
            repeat (3) begin
                @(negedge clk);
                n_checks++;
                if (dut_vec !== mdl_vec) begin
                    n_fail++;
                    $display("FAIL overflow_model e=%0d dut=%h model=%h", e, dut_vec, mdl_vec);
                end
            end
        end
        n_checks++;
        if (count !== 3'd4 || ovf !== 8'd1 || valid !== 1'b1 || evnum !== 16'd0) begin
            n_fail++;
            $display("FAIL overflow_full cnt=%0d ovf=%0d v=%b ev=%0d want 4/1/1/0",
                     count, ovf, valid, evnum);
        end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (valid !== 1'b1 || evnum !== 16'(k)) begin
                n_fail++;
                $display("FAIL overflow_drain k=%0d v=%b ev=%0d want 1/%0d", k, valid, evnum, k);
            end
            @(negedge clk);
        end
        ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_empty cnt=%0d v=%b want 0/0", count, valid);
        end
        g_trig = 1'b1;
        @(negedge clk);
        g_trig = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || evnum !== 16'd5 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL overflow_gap v=%b ev=%0d cnt=%0d want 1/5/1", valid, evnum, count);
        end
    endtask

    task automatic test_ignore_retrigger();
        int pulses;
        do_reset();
        win    = 4'd5;
        pulses = 0;
        g_trig = 1'b1;
        @(negedge clk);
        pulses += int'(event_flag);
        g_trig = 1'b0;
        @(negedge clk);
        pulses += int'(event_flag);
        g_trig = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pulses += int'(event_flag);
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL retrig_model k=%0d dut=%h model=%h", k, dut_vec, mdl_vec);
            end
        end
        n_checks++;
        if (pulses != 1 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL retrig_ignored pulses=%0d cnt=%0d want 1/1", pulses, count);
        end
        g_trig = 1'b0;
    endtask

    task automatic test_enable_drop();
        int pulses;
        do_reset();
        win    = 4'd4;
        g_trig = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        g_trig = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL enable_model k=%0d dut=%h model=%h", k, dut_vec, mdl_vec);
            end
        end
        n_checks++;
        if (count !== 3'd1 || evnum !== 16'd0) begin
            n_fail++;
            $display("FAIL enable_completes cnt=%0d ev=%0d want 1/0", count, evnum);
        end
        pulses = 0;
        g_trig = 1'b1;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(event_flag);
        end
        n_checks++;
        if (pulses != 0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL enable_blocked pulses=%0d cnt=%0d want 0/1", pulses, count);
        end
        g_trig = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_midwindow();
        do_reset();
        win = 4'd0;
        repeat (2) begin
            g_trig = 1'b1;
            @(negedge clk);
            g_trig = 1'b0;
            repeat (3) @(negedge clk);
        end
        win    = 4'd8;
        g_trig = 1'b1;
        trigs  = 4'b0011;
        @(negedge clk);
        g_trig = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL midwin_setup busy=%b cnt=%0d want 1/2", busy, count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL midwin_reset outputs=%h want 0", dut_vec);
        end
        rst_n = 1'b1;
        win   = 4'd0;
        trigs = '0;
        @(negedge clk);
        g_trig = 1'b1;
        @(negedge clk);
        g_trig = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || evnum !== 16'd0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL midwin_evnum v=%b ev=%0d cnt=%0d want 1/0/1", valid, evnum, count);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int pops;
        do_reset();
        win    = 4'd0;
        ready  = 1'b1;
        pulses = 0;
        pops   = 0;
        for (int k = 0; k < 19; k++) begin
            g_trig = (k < 16) && (k % 2 == 0);
            @(negedge clk);
            pulses += int'(event_flag);
            if (valid && ready) pops++;
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL b2b_model k=%0d dut=%h model=%h", k, dut_vec, mdl_vec);
            end
        end
        n_checks++;
        if (pulses != 8 || pops != 8) begin
            n_fail++;
            $display("FAIL b2b_throughput pulses=%0d pops=%0d want 8/8", pulses, pops);
        end
        ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            rst_n  = ($urandom_range(0, 149) != 0);
            enable = ($urandom_range(0, 7) != 0);
            g_trig = $urandom_range(0, 1) == 1;
            trigs  = NT'($urandom);
            win    = WW'($urandom_range(0, 6));
            ready  = ($urandom_range(0, 3) < ((i / 200) % 4));
            @(negedge clk);
            n_checks++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL random_model i=%0d dut=%h model=%h", i, dut_vec, mdl_vec);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_window_pattern();
        test_overflow();
        test_ignore_retrigger();
        test_enable_drop();
        test_reset_midwindow();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
